// File: rtl/cprv_pkg.sv
// Shared types and default widths for the cprv write-back path.
package cprv_pkg;

  localparam int unsigned DefaultDataWidth    = 64;
  localparam int unsigned DefaultRegaddrWidth = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/cprv_scoreboard.sv
// Register busy vector: a bit is set when a producer issues and cleared when its write commits.
module cprv_scoreboard #(
  parameter int unsigned ADDR_WIDTH = cprv_pkg::DefaultRegaddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int unsigned Entries = 2 ** ADDR_WIDTH;

  logic [Entries-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    // Applied after the clear so a new producer of the same register wins.
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: rtl/cprv_wb_arbiter.sv
// Round-robin ALU/LSU write-back arbiter with a registered regfile write port.
// Define CPRV_WB_SCOREBOARD_EN to add the busy-register scoreboard for hazard queries.
module cprv_wb_arbiter
  import cprv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned REGADDR_WIDTH = DefaultRegaddrWidth
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REGADDR_WIDTH-1:0] alu_rd_addr,
  input  logic [DATA_WIDTH-1:0]    alu_rd_data,

  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REGADDR_WIDTH-1:0] lsu_rd_addr,
  input  logic [DATA_WIDTH-1:0]    lsu_rd_data,

  output logic                     rd_en,
  output logic [REGADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,

  input  logic                     issue_en,
  input  logic [REGADDR_WIDTH-1:0] issue_addr,

  input  logic [REGADDR_WIDTH-1:0] rs1_addr,
  input  logic [REGADDR_WIDTH-1:0] rs2_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy
);

  req_id_e                  last_grant_q, last_grant_d;
  logic                     rd_en_q, rd_en_d;
  logic [REGADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        // Contention goes to whichever side did not win last time.
        if (last_grant_q == REQ_LSU) begin
          alu_ready = 1'b1;
        end else begin
          lsu_ready = 1'b1;
        end
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    if (alu_ready) begin
      last_grant_d = REQ_ALU;
      rd_en_d      = (alu_rd_addr != '0);
      rd_addr_d    = alu_rd_addr;
      rd_data_d    = alu_rd_data;
    end else if (lsu_ready) begin
      last_grant_d = REQ_LSU;
      rd_en_d      = (lsu_rd_addr != '0);
      rd_addr_d    = lsu_rd_addr;
      rd_data_d    = lsu_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_LSU;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;

`ifdef CPRV_WB_SCOREBOARD_EN
  cprv_scoreboard #(
    .ADDR_WIDTH(REGADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_en),
    .set_addr(issue_addr),
    .clr_en  (rd_en_q),
    .clr_addr(rd_addr_q),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy)
  );
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_en, issue_addr, rs1_addr, rs2_addr};
  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_cprv_wb_arbiter.sv
// Self-checking bench for cprv_wb_arbiter: a reference model queues the expected write port
// contents each cycle and compares them when the registered output appears.
module tb_cprv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd_addr, lsu_rd_addr, rd_addr, issue_addr, rs1_addr, rs2_addr;
  logic [63:0] alu_rd_data, lsu_rd_data, rd_data;
  logic        rd_en, issue_en, rs1_busy, rs2_busy;

  always #5 clk = ~clk;

  cprv_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd_addr(alu_rd_addr),
    .alu_rd_data(alu_rd_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd_addr(lsu_rd_addr),
    .lsu_rd_data(lsu_rd_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_t;

  wb_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_last_lsu = 1'b1;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
`ifdef CPRV_WB_SCOREBOARD_EN
  logic [31:0] m_busy = '0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational and registered outputs, advance model.
  task automatic step(input logic r,
                      input logic av, input logic [4:0] aa, input logic [63:0] ad,
                      input logic lv, input logic [4:0] la, input logic [63:0] ld,
                      input logic ie, input logic [4:0] ia,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic ag, lg, cur_en;
    logic [4:0] cur_addr;
    wb_t e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd_addr = aa; alu_rd_data = ad;
    lsu_valid = lv; lsu_rd_addr = la; lsu_rd_data = ld;
    issue_en = ie; issue_addr = ia; rs1_addr = r1; rs2_addr = r2;
    #1;
    ag = !r && av && (!lv || m_last_lsu);
    lg = !r && lv && (!av || !m_last_lsu);
    check_eq("alu_ready", {63'd0, alu_ready}, {63'd0, ag});
    check_eq("lsu_ready", {63'd0, lsu_ready}, {63'd0, lg});
    cur_en = 1'b0;
    cur_addr = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("rd_en", {63'd0, rd_en}, {63'd0, e.en});
      check_eq("rd_addr", {59'd0, rd_addr}, {59'd0, e.addr});
      check_eq("rd_data", rd_data, e.data);
      cur_en = e.en;
      cur_addr = e.addr;
    end
`ifdef CPRV_WB_SCOREBOARD_EN
    check_eq("rs1_busy", {63'd0, rs1_busy}, {63'd0, m_busy[r1]});
    check_eq("rs2_busy", {63'd0, rs2_busy}, {63'd0, m_busy[r2]});
    if (r) m_busy = '0;
    else begin
      if (cur_en) m_busy[cur_addr] = 1'b0;
      if (ie) m_busy[ia] = 1'b1;
      m_busy[0] = 1'b0;
    end
`else
    check_eq("rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check_eq("rs2_busy", {63'd0, rs2_busy}, 64'd0);
`endif
    if (r) begin
      m_last_lsu = 1'b1; m_addr = '0; m_data = '0;
      exp_q.push_back('{en: 1'b0, addr: 5'd0, data: 64'd0});
    end else if (ag) begin
      m_last_lsu = 1'b0; m_addr = aa; m_data = ad;
      exp_q.push_back('{en: (aa != 5'd0), addr: aa, data: ad});
    end else if (lg) begin
      m_last_lsu = 1'b1; m_addr = la; m_data = ld;
      exp_q.push_back('{en: (la != 5'd0), addr: la, data: ld});
    end else begin
      exp_q.push_back('{en: 1'b0, addr: m_addr, data: m_data});
    end
  endtask

  task automatic idle(input logic [4:0] r1);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, r1, 5'd0);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; alu_rd_addr = '0; lsu_rd_addr = '0;
    alu_rd_data = '0; lsu_rd_data = '0; issue_en = 1'b0; issue_addr = '0;
    rs1_addr = '0; rs2_addr = '0;

    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 5'd0, 5'd0);

    // Contention after reset: ALU first, then the waiting LSU.
    step(1'b0, 1'b1, 5'd3, 64'hA3, 1'b1, 5'd4, 64'hB4, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 64'hB4, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0);

    // Sustained contention alternates grants with a write every cycle.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 5'(8 + i), 64'h1000 + 64'(i), 1'b1, 5'(16 + i), 64'h2000 + 64'(i),
           1'b0, 5'd0, 5'd0, 5'd0);
    end
    idle(5'd0);

    // x0 write is accepted but dropped.
    step(1'b0, 1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0);

    // Scoreboard: issue, commit clears; issue in the commit cycle keeps the bit set.
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd5);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd7, 5'd5);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 5'd7, 5'd5);
    idle(5'd7);
    idle(5'd7);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h78, 1'b1, 5'd7, 5'd7, 5'd5);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd5);
    idle(5'd7);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0);

    // Reset during a grant: nothing written, busy cleared, ALU wins next contention.
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 64'hC, 1'b1, 5'd12, 5'd12, 5'd7);
    step(1'b1, 1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'hAA, 1'b0, 5'd0, 5'd12, 5'd7);
    step(1'b0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'hAA, 1'b0, 5'd0, 5'd12, 5'd7);
    idle(5'd12);

    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'($urandom), 5'($urandom), {$urandom, $urandom},
           1'($urandom), 5'($urandom), {$urandom, $urandom},
           1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end
    idle(5'd0);
    idle(5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
